// File: rtl/seq_adder_nbit.sv
// seq_adder_nbit: multi-cycle WIDTH-bit adder/subtractor.
// Adds CHUNK bits per cycle with a registered inter-chunk carry.
module seq_adder_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             carry_in,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  // FIN commits the flags one cycle after the last chunk,
  // so a result is visible NCHUNK+1 edges after accept.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic [CW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cmsb;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_ch;
  logic [CHUNK-1:0] w_b_ch;
  logic [CHUNK:0]   w_sum;
  logic             w_cmsb;
  logic             w_last;
  logic [31:0]      w_lsb;
  logic             w_in_ready;
  logic             w_out_valid;

  // Operands shift right each CALC cycle; the low chunk is live.
  assign w_a_ch = r_a[CHUNK-1:0];
  assign w_b_ch = r_b[CHUNK-1:0];
  assign w_sum  = {1'b0, w_a_ch}
                + {1'b0, w_b_ch}
                + {{CHUNK{1'b0}}, r_carry};
  assign w_cmsb = w_a_ch[CHUNK-1]
                ^ w_b_ch[CHUNK-1]
                ^ w_sum[CHUNK-1];
  assign w_last = (r_idx == LAST);
  assign w_lsb  = 32'(r_idx) * 32'(CHUNK);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = CALC;
      CALC:    if (w_last)    w_next = FIN;
      FIN:                    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default:                w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    unique case (r_state)
      IDLE:    w_in_ready  = 1'b1;
      DONE:    w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch operands, ripple chunks, commit flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= sub ? ~in_b : in_b;
            r_carry <= sub | carry_in;
            r_idx   <= '0;
          end
        end
        CALC: begin
          r_a <= r_a >> CHUNK;
          r_b <= r_b >> CHUNK;
          r_out[w_lsb +: CHUNK] <= w_sum[CHUNK-1:0];
          r_carry <= w_sum[CHUNK];
          r_cmsb  <= w_cmsb;
          r_idx   <= r_idx + 1'b1;
        end
        FIN: begin
          r_cout <= r_carry;
          r_ovf  <= r_cmsb ^ r_carry;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out       = r_out;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_seq_adder_nbit.sv
// tb_seq_adder_nbit: scoreboard bench for seq_adder_nbit
// at 16/4, 8/8 and 32/4 against an integer A +/- B model.
module tb_seq_adder_nbit;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  int n_done;
  initial begin
    n_vec  = 0;
    n_bad  = 0;
    n_done = 0;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : G
    localparam int W  = (g == 1) ? 8 : (g == 2) ? 32 : 16;
    localparam int C  = (g == 1) ? 8 : 4;
    localparam int NC = W / C;

    logic         reset;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         carry_in;
    logic         sub;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         carry_out;
    logic         overflow;
    logic         out_valid;
    logic         out_ready;

    logic [W+1:0] exp_q[$];

    seq_adder_nbit #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_a      (in_a),
      .in_b      (in_b),
      .carry_in  (carry_in),
      .sub       (sub),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .carry_out (carry_out),
      .overflow  (overflow),
      .out_valid (out_valid),
      .out_ready (out_ready)
    );

    // Reference: integer arithmetic on unsigned and signed views.
    function automatic logic [W+1:0] model(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic         ci,
      input logic         s
    );
      longint m, ua, ub, sa, sv, r, sr;
      logic   c, v;
      m  = longint'(1) << W;
      ua = longint'(a);
      ub = longint'(b);
      sa = a[W-1] ? ua - m : ua;
      sv = b[W-1] ? ub - m : ub;
      if (s) begin
        r  = ua - ub;
        c  = (ua >= ub);
        sr = sa - sv;
      end else begin
        r  = ua + ub + longint'(ci);
        c  = (r >= m);
        sr = sa + sv + longint'(ci);
      end
      v = (sr >= m / 2) || (sr < -(m / 2));
      return {v, c, W'(r)};
    endfunction

    task automatic wait_ready();
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("g%0d accept", g), 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic         ci,
                         input logic         s,
                         input int           hold,
                         input logic [W+1:0] e);
      int lat;
      @(posedge clk);
      #1;
      in_a      = a;
      in_b      = b;
      carry_in  = ci;
      sub       = s;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      wait_ready();
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      sub      = ~s;
      carry_in = ~ci;
      if (hold == 0) out_ready = 1'b1;
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end while (!out_valid && lat < 100);
      chk($sformatf("g%0d latency", g), 64'(lat), 64'(NC + 1));
      if (hold > 0) begin
        for (int i = 0; i < hold; i++) begin
          chk($sformatf("g%0d bp valid", g), 64'(out_valid), 64'd1);
          chk($sformatf("g%0d bp in_ready", g), 64'(in_ready), 64'd0);
          chk($sformatf("g%0d bp result", g),
              64'({overflow, carry_out, out}), 64'(e));
          @(posedge clk);
          #1;
          in_valid = 1'b1;
          in_a     = W'($urandom);
          in_b     = W'($urandom);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("g%0d post valid", g), 64'(out_valid), 64'd0);
      chk($sformatf("g%0d post in_ready", g), 64'(in_ready), 64'd1);
    endtask

    task automatic check_idle_zero(input string nm);
      chk($sformatf("g%0d %s in_ready", g, nm), 64'(in_ready), 64'd1);
      chk($sformatf("g%0d %s out_valid", g, nm), 64'(out_valid), 64'd0);
      chk($sformatf("g%0d %s out", g, nm), 64'(out), 64'd0);
      chk($sformatf("g%0d %s carry", g, nm), 64'(carry_out), 64'd0);
      chk($sformatf("g%0d %s ovf", g, nm), 64'(overflow), 64'd0);
    endtask

    task automatic do_reset_mid();
      @(posedge clk);
      #1;
      in_a      = W'(9);
      in_b      = W'(6);
      carry_in  = 1'b0;
      sub       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      wait_ready();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_idle_zero("midreset");
      do_op(W'(3), W'(4), 1'b0, 1'b0, 1, {2'b00, W'(7)});
    endtask

    // Monitor: pop and compare on every result transfer.
    always @(negedge clk) begin
      logic [W+1:0] e;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL g%0d unexpected result: got %0h, want none",
                   g, out);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("g%0d out", g), 64'(out), 64'(e[W-1:0]));
          chk($sformatf("g%0d carry_out", g),
              64'(carry_out), 64'(e[W]));
          chk($sformatf("g%0d overflow", g),
              64'(overflow), 64'(e[W+1]));
        end
      end
    end

    // Driver: reset, directed corners, mid-op reset, random sweep.
    initial begin
      logic [W-1:0] ra, rb, mx;
      logic         rc, rs;
      reset     = 1'b1;
      in_a      = '0;
      in_b      = '0;
      carry_in  = 1'b0;
      sub       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_idle_zero("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk($sformatf("g%0d first in_ready", g), 64'(in_ready), 64'd1);

      if (W == 16) begin
        do_op(W'(16'hFFFF), W'(16'h0001), 1'b0, 1'b0, 0,
              {2'b01, W'(16'h0000)});
        do_op(W'(16'h7FFF), W'(16'h0001), 1'b0, 1'b0, 3,
              {2'b10, W'(16'h8000)});
        do_op(W'(16'h1234), W'(16'h4321), 1'b1, 1'b0, 1,
              {2'b00, W'(16'h5556)});
        do_op(W'(16'h0005), W'(16'h0007), 1'b1, 1'b1, 0,
              {2'b00, W'(16'hFFFE)});
        do_op(W'(16'h8000), W'(16'h0001), 1'b0, 1'b1, 2,
              {2'b11, W'(16'h7FFF)});
      end

      mx = {1'b0, {(W-1){1'b1}}};
      do_op('1, W'(1), 1'b0, 1'b0, 0, model('1, W'(1), 1'b0, 1'b0));
      do_op(mx, W'(1), 1'b0, 1'b0, 3, model(mx, W'(1), 1'b0, 1'b0));
      do_op(~mx, W'(1), 1'b1, 1'b1, 1, model(~mx, W'(1), 1'b1, 1'b1));

      do_reset_mid();

      for (int i = 0; i < 40; i++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        if ($urandom_range(0, 3) == 0) rb = ~ra;
        rc = 1'($urandom);
        rs = 1'($urandom);
        do_op(ra, rb, rc, rs, int'($urandom_range(0, 3)),
              model(ra, rb, rc, rs));
      end

      repeat (4) @(negedge clk);
      chk($sformatf("g%0d queue drained", g),
          64'(exp_q.size()), 64'd0);
      n_done++;
    end
  end

  initial begin
    int t;
    t = 0;
    while (n_done < 3 && t < 60000) begin
      @(posedge clk);
      t++;
    end
    if (n_done < 3) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got %0d drivers done, want 3", n_done);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
